// File: rtl/window_sequencer_if.sv
// Pixel-in / window-out signal bundle for the 3x3 window sequencer.
// The slave modport is the sequencer side; the master modport is the pixel source / window consumer.
interface window_sequencer_if #(
  parameter int CW = 10,
  parameter int RW = 9
);
  logic          sof;
  logic          pix_valid;
  logic          in_ready;
  logic          lb_shift;
  logic          win_valid;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic [3:0]    border;
  logic          frame_done;
  logic          timeout_err;
  logic          busy;

  modport master (
    output sof, pix_valid,
    input  in_ready, lb_shift, win_valid, out_col, out_row, border,
           frame_done, timeout_err, busy
  );

  modport slave (
    input  sof, pix_valid,
    output in_ready, lb_shift, win_valid, out_col, out_row, border,
           frame_done, timeout_err, busy
  );
endinterface

// File: rtl/window_sequencer.sv
// Raster sequencer for the 3x3 line-buffer window: tracks the input index, emits windows
// lagging one line plus one pixel, flushes the tail at end of frame, and aborts on a stalled source.
module window_sequencer #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int TIMEOUT = 65535,
  parameter int CW      = $clog2(IMG_W),
  parameter int RW      = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  window_sequencer_if.slave bus
);

  localparam int NPIX      = IMG_W * IMG_H;
  localparam int LAST_TICK = NPIX + IMG_W;
  localparam int IW        = $clog2(LAST_TICK + 1);
  localparam int WW        = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [CW-1:0] cen_col_q, cen_col_d, out_col_q, out_col_d;
  logic [RW-1:0] cen_row_q, cen_row_d, out_row_q, out_row_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          timeout_err_q, timeout_err_d;
  logic          in_ready, accept, tick, lb_shift;

  assign in_ready = (state_q != FLUSH);
  assign accept   = bus.pix_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wd_d          = '0;
    cen_col_d     = cen_col_q;
    cen_row_d     = cen_row_q;
    out_col_d     = out_col_q;
    out_row_d     = out_row_q;
    win_valid_d   = 1'b0;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    tick          = 1'b0;
    lb_shift      = 1'b0;

    // idx_q is the linear index the next accepted pixel (or flush tick) will carry
    case (state_q)
      IDLE: begin
        if (accept && bus.sof) begin
          lb_shift      = 1'b1;
          idx_d         = IW'(1);
          cen_col_d     = '0;
          cen_row_d     = '0;
          timeout_err_d = 1'b0;
          state_d       = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          lb_shift = 1'b1;
          if (bus.sof) begin
            idx_d         = IW'(1);
            cen_col_d     = '0;
            cen_row_d     = '0;
            timeout_err_d = 1'b0;
          end else begin
            tick  = 1'b1;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(NPIX - 1)) state_d = FLUSH;
          end
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      FLUSH: begin
        lb_shift = 1'b1;
        tick     = 1'b1;
        idx_d    = idx_q + IW'(1);
        if (idx_q == IW'(LAST_TICK)) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Windows trail the input by one line plus one pixel, so centres simply count up in raster order
    if (tick && idx_q >= IW'(IMG_W + 1)) begin
      win_valid_d = 1'b1;
      out_col_d   = cen_col_q;
      out_row_d   = cen_row_q;
      if (cen_col_q == CW'(IMG_W - 1)) begin
        cen_col_d = '0;
        cen_row_d = (cen_row_q == RW'(IMG_H - 1)) ? '0 : cen_row_q + RW'(1);
      end else begin
        cen_col_d = cen_col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      wd_q          <= '0;
      cen_col_q     <= '0;
      cen_row_q     <= '0;
      out_col_q     <= '0;
      out_row_q     <= '0;
      win_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wd_q          <= wd_d;
      cen_col_q     <= cen_col_d;
      cen_row_q     <= cen_row_d;
      out_col_q     <= out_col_d;
      out_row_q     <= out_row_d;
      win_valid_q   <= win_valid_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.lb_shift    = lb_shift;
  assign bus.win_valid   = win_valid_q;
  assign bus.out_col     = out_col_q;
  assign bus.out_row     = out_row_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.border      = win_valid_q ? {out_row_q == RW'(0), out_row_q == RW'(IMG_H - 1),
                                          out_col_q == CW'(0), out_col_q == CW'(IMG_W - 1)} : 4'b0000;
  // Busy also covers the final flush window, which lands the cycle after the state returns to IDLE
  assign bus.busy        = (state_q != IDLE) | win_valid_q;

endmodule

// File: tb/tb_window_sequencer.sv
// Self-checking bench for window_sequencer on an 8x4 image with a 16-cycle watchdog.
// A linear-index model predicts every output each cycle; literal checks pin the scenario totals.
module tb_window_sequencer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int TO = 16;

  logic clk;
  logic rst_n;

  window_sequencer_if #(.CW(3), .RW(2)) bus ();

  window_sequencer #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run;
  int tests_failed;

  // Model state: mode 0 idle, 1 run, 2 flush; k = linear index of the next pixel/tick
  int   m_mode, m_k, m_wd, m_row, m_col;
  logic m_wv, m_fd, m_err;

  // Scenario statistics gathered from DUT outputs
  int   cyc, win_count, fd_count, noready_count;
  int   first_cyc, first_row, first_col, fd_cyc, fd_row, fd_col;
  logic [3:0] first_border, fd_border;
  logic busy_at_fd, busy_after_fd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v);
    bus.sof       = s;
    bus.pix_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    cyc = 0; win_count = 0; fd_count = 0; noready_count = 0;
    first_cyc = -1; first_row = -1; first_col = -1; first_border = 4'b0;
    fd_cyc = -1; fd_row = -1; fd_col = -1; fd_border = 4'b0;
    busy_at_fd = 1'b0; busy_after_fd = 1'b1;
  endtask

  task automatic sendPixels(input int count, input logic first_sof, input logic gap);
    for (int p = 0; p < count; p++) begin
      applyStimulus(first_sof && (p == 0), 1'b1);
      if (gap) applyStimulus(1'b0, 1'b0);
    end
  endtask

  task automatic idleCycles(input int count);
    for (int i = 0; i < count; i++) applyStimulus(1'b0, 1'b0);
  endtask

  // Reference model: window centre = accepted index minus one line minus one pixel
  always @(posedge clk or negedge rst_n) begin
    int mode, k, wd, c;
    logic wv, fd, err, acc;
    if (!rst_n) begin
      m_mode <= 0; m_k <= 0; m_wd <= 0; m_row <= 0; m_col <= 0;
      m_wv <= 1'b0; m_fd <= 1'b0; m_err <= 1'b0;
    end else begin
      mode = m_mode; k = m_k; wd = m_wd; err = m_err;
      wv = 1'b0; fd = 1'b0; c = 0;
      acc = bus.pix_valid && (mode != 2);
      case (mode)
        0: if (acc && bus.sof) begin
             mode = 1; k = 1; wd = 0; err = 1'b0;
           end
        1: if (acc) begin
             wd = 0;
             if (bus.sof) begin
               k = 1;
             end else begin
               if (k >= W + 1) begin wv = 1'b1; c = k - W - 1; end
               if (k == N - 1) mode = 2;
               k = k + 1;
             end
           end else begin
             wd = wd + 1;
             if (wd == TO) begin mode = 0; err = 1'b1; wd = 0; end
           end
        default: begin
             wv = 1'b1; c = k - W - 1;
             if (k == N + W) begin fd = 1'b1; mode = 0; end
             k = k + 1;
           end
      endcase
      m_mode <= mode; m_k <= k; m_wd <= wd; m_err <= err;
      m_wv <= wv; m_fd <= fd;
      if (wv) begin m_row <= c / W; m_col <= c % W; end
    end
  end

  // Compare process: every cycle, mid-period
  always @(negedge clk) begin
    logic e_shift, e_busy;
    logic [3:0] e_border;
    e_shift  = (m_mode == 0) ? (bus.pix_valid && bus.sof) : (m_mode == 1) ? bus.pix_valid : 1'b1;
    e_busy   = (m_mode != 0) || m_wv;
    e_border = {m_row == 0, m_row == H - 1, m_col == 0, m_col == W - 1};
    checkOutput("in_ready", 32'(bus.in_ready), 32'(m_mode != 2));
    checkOutput("lb_shift", 32'(bus.lb_shift), 32'(e_shift));
    checkOutput("win_valid", 32'(bus.win_valid), 32'(m_wv));
    checkOutput("frame_done", 32'(bus.frame_done), 32'(m_fd));
    checkOutput("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    checkOutput("busy", 32'(bus.busy), 32'(e_busy));
    if (m_wv) begin
      checkOutput("out_row", 32'(bus.out_row), 32'(m_row));
      checkOutput("out_col", 32'(bus.out_col), 32'(m_col));
      checkOutput("border", 32'(bus.border), 32'(e_border));
    end
    if (bus.win_valid) begin
      if (win_count == 0) begin
        first_cyc = cyc; first_row = int'(bus.out_row); first_col = int'(bus.out_col);
        first_border = bus.border;
      end
      win_count++;
    end
    if (bus.frame_done) begin
      fd_count++; fd_cyc = cyc; fd_row = int'(bus.out_row); fd_col = int'(bus.out_col);
      fd_border = bus.border; busy_at_fd = bus.busy;
    end
    if (fd_cyc >= 0 && cyc == fd_cyc + 1) busy_after_fd = bus.busy;
    if (!bus.in_ready) noready_count++;
    cyc++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "[TB] aborted");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    clearStats();
    rst_n = 1'b0; bus.sof = 1'b0; bus.pix_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_win_valid", 32'(bus.win_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] contiguous frame");
    clearStats();
    sendPixels(N, 1'b1, 1'b0);
    idleCycles(12);
    checkOutput("f1_windows", 32'(win_count), 32'd32);
    checkOutput("f1_first_cycle", 32'(first_cyc), 32'd10);
    checkOutput("f1_first_row", 32'(first_row), 32'd0);
    checkOutput("f1_first_col", 32'(first_col), 32'd0);
    checkOutput("f1_first_border", 32'(first_border), 32'b1010);
    checkOutput("f1_flush_len", 32'(noready_count), 32'd9);
    checkOutput("f1_frame_done", 32'(fd_count), 32'd1);
    checkOutput("f1_fd_cycle", 32'(fd_cyc), 32'd41);
    checkOutput("f1_fd_row", 32'(fd_row), 32'd3);
    checkOutput("f1_fd_col", 32'(fd_col), 32'd7);
    checkOutput("f1_fd_border", 32'(fd_border), 32'b0101);
    checkOutput("f1_busy_at_fd", 32'(busy_at_fd), 32'd1);
    checkOutput("f1_busy_after_fd", 32'(busy_after_fd), 32'd0);

    $display("[TB] gapped frame");
    clearStats();
    sendPixels(N, 1'b1, 1'b1);
    idleCycles(12);
    checkOutput("f2_windows", 32'(win_count), 32'd32);
    checkOutput("f2_first_cycle", 32'(first_cyc), 32'd19);
    checkOutput("f2_frame_done", 32'(fd_count), 32'd1);
    checkOutput("f2_fd_cycle", 32'(fd_cyc), 32'd72);

    $display("[TB] idle pixels without sof");
    clearStats();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_windows", 32'(win_count), 32'd0);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    $display("[TB] restart at pixel 20");
    clearStats();
    sendPixels(20, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rs_pre_windows", 32'(win_count), 32'd11);
    checkOutput("rs_pre_frame_done", 32'(fd_count), 32'd0);
    clearStats();
    sendPixels(N - 1, 1'b0, 1'b0);
    idleCycles(12);
    checkOutput("rs_windows", 32'(win_count), 32'd32);
    checkOutput("rs_first_row", 32'(first_row), 32'd0);
    checkOutput("rs_first_col", 32'(first_col), 32'd0);
    checkOutput("rs_frame_done", 32'(fd_count), 32'd1);
    checkOutput("rs_fd_cycle", 32'(fd_cyc), 32'd40);

    $display("[TB] watchdog");
    clearStats();
    sendPixels(13, 1'b1, 1'b0);
    idleCycles(TO - 1);
    checkOutput("wd_err_before", 32'(bus.timeout_err), 32'd0);
    checkOutput("wd_busy_before", 32'(bus.busy), 32'd1);
    idleCycles(1);
    checkOutput("wd_err_after", 32'(bus.timeout_err), 32'd1);
    checkOutput("wd_busy_after", 32'(bus.busy), 32'd0);
    checkOutput("wd_windows", 32'(win_count), 32'd4);
    checkOutput("wd_frame_done", 32'(fd_count), 32'd0);
    clearStats();
    applyStimulus(1'b1, 1'b1);
    checkOutput("wd_err_cleared", 32'(bus.timeout_err), 32'd0);
    sendPixels(N - 1, 1'b0, 1'b0);
    idleCycles(12);
    checkOutput("wd_next_windows", 32'(win_count), 32'd32);
    checkOutput("wd_next_frame_done", 32'(fd_count), 32'd1);

    $display("[TB] reset during flush");
    clearStats();
    sendPixels(N, 1'b1, 1'b0);
    idleCycles(3);
    rst_n = 1'b0;
    #1;
    checkOutput("ar_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("ar_lb_shift", 32'(bus.lb_shift), 32'd0);
    checkOutput("ar_win_valid", 32'(bus.win_valid), 32'd0);
    checkOutput("ar_busy", 32'(bus.busy), 32'd0);
    checkOutput("ar_border", 32'(bus.border), 32'd0);
    checkOutput("ar_out_col", 32'(bus.out_col), 32'd0);
    checkOutput("ar_out_row", 32'(bus.out_row), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleCycles(12);
    checkOutput("ar_no_frame_done", 32'(fd_count), 32'd0);
    clearStats();
    sendPixels(N, 1'b1, 1'b0);
    idleCycles(12);
    checkOutput("ar_windows", 32'(win_count), 32'd32);
    checkOutput("ar_frame_done", 32'(fd_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
